// File: rtl/class_score_accumulator.sv
// Per-class dot-product engine: scans every grid cell of a weight ROM / feature RAM pair and emits sum(w*f).
// Build option SCORE_SATURATE_EN: per-step saturating accumulation plus a sat_flag output.
module class_score_accumulator #(
  parameter int NUM_CELLS   = 256,
  parameter int WEIGHT_BITS = 8,
  parameter int FEAT_BITS   = 8,
  parameter int ACC_BITS    = 24
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               start,
  output logic                               busy,
  output logic [$clog2(NUM_CELLS)-1:0]       cell_addr,
  input  logic signed [WEIGHT_BITS-1:0]      w_data,
  input  logic        [FEAT_BITS-1:0]        f_data,
  output logic signed [ACC_BITS-1:0]         score,
  output logic                               score_valid
`ifdef SCORE_SATURATE_EN
  ,
  output logic                               sat_flag
`endif
);

  localparam int ADDR_BITS = $clog2(NUM_CELLS);
  // signed*unsigned magnitude is below 2^(W+F-1), so W+F bits hold the product exactly
  localparam int PROD_BITS = WEIGHT_BITS + FEAT_BITS;
  localparam logic [ADDR_BITS-1:0] LAST_ADDR = ADDR_BITS'(NUM_CELLS - 1);

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DRAIN,
    DONE
  } state_t;

  state_t                      state;
  logic                        rd_vld;
  logic signed [ACC_BITS-1:0]  acc;
  logic signed [ACC_BITS-1:0]  acc_next;
  logic signed [PROD_BITS-1:0] w_ext;
  logic signed [PROD_BITS-1:0] f_ext;
  logic signed [PROD_BITS-1:0] product;

`ifdef SCORE_SATURATE_EN
  localparam logic signed [ACC_BITS:0] SAT_MAX = {2'b00, {(ACC_BITS-1){1'b1}}};
  localparam logic signed [ACC_BITS:0] SAT_MIN = {2'b11, {(ACC_BITS-1){1'b0}}};

  logic signed [ACC_BITS:0] sum_ext;
  logic                     clamp;
  logic                     sat_seen;
`endif

  always_comb begin
    w_ext   = PROD_BITS'(w_data);
    f_ext   = PROD_BITS'(f_data);
    product = w_ext * f_ext;
`ifdef SCORE_SATURATE_EN
    // one guard bit is enough to see the overflow of a single step
    sum_ext = (ACC_BITS+1)'(acc) + (ACC_BITS+1)'(product);
    clamp   = 1'b0;
    if (sum_ext > SAT_MAX) begin
      acc_next = SAT_MAX[ACC_BITS-1:0];
      clamp    = 1'b1;
    end else if (sum_ext < SAT_MIN) begin
      acc_next = SAT_MIN[ACC_BITS-1:0];
      clamp    = 1'b1;
    end else begin
      acc_next = sum_ext[ACC_BITS-1:0];
    end
`else
    acc_next = acc + ACC_BITS'(product);
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cell_addr   <= '0;
      busy        <= 1'b0;
      score       <= '0;
      score_valid <= 1'b0;
      acc         <= '0;
      rd_vld      <= 1'b0;
`ifdef SCORE_SATURATE_EN
      sat_flag    <= 1'b0;
      sat_seen    <= 1'b0;
`endif
    end else begin
      score_valid <= 1'b0;
      // rd_vld trails the address by one cycle to line up with the synchronous read data
      if (rd_vld) begin
        acc <= acc_next;
`ifdef SCORE_SATURATE_EN
        if (clamp) sat_seen <= 1'b1;
`endif
      end
      case (state)
        IDLE: begin
          if (start) begin
            acc       <= '0;
            cell_addr <= '0;
            busy      <= 1'b1;
            state     <= SCAN;
`ifdef SCORE_SATURATE_EN
            sat_flag  <= 1'b0;
            sat_seen  <= 1'b0;
`endif
          end
        end
        SCAN: begin
          rd_vld <= 1'b1;
          if (cell_addr == LAST_ADDR) begin
            state <= DRAIN;
          end else begin
            cell_addr <= cell_addr + ADDR_BITS'(1);
          end
        end
        DRAIN: begin
          rd_vld <= 1'b0;
          state  <= DONE;
        end
        DONE: begin
          score       <= acc;
          score_valid <= 1'b1;
          cell_addr   <= '0;
          busy        <= 1'b0;
          state       <= IDLE;
`ifdef SCORE_SATURATE_EN
          sat_flag    <= sat_seen;
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_class_score_accumulator.sv
// Bench for class_score_accumulator: a 24-bit and a 16-bit accumulator scan the same ROM/feature contents
// side by side; honours SCORE_SATURATE_EN for the sat_flag port and the narrow-width expectations.
module tb_class_score_accumulator;

  localparam int N  = 256;
  localparam int AW = 24;
  localparam int AN = 16;
`ifdef SCORE_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  addr_w, addr_n;
  logic [7:0]  w_w, f_w, w_n, f_n;
  logic        busy_w, busy_n, val_w, val_n;
  logic [AW-1:0] score_w;
  logic [AN-1:0] score_n;
`ifdef SCORE_SATURATE_EN
  logic        sat_w, sat_n;
`endif

  int wrom [N];
  int from [N];
  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  class_score_accumulator #(.NUM_CELLS(N), .WEIGHT_BITS(8), .FEAT_BITS(8), .ACC_BITS(AW)) u_wide (
    .clk(clk), .rst(rst), .start(start), .busy(busy_w), .cell_addr(addr_w),
    .w_data(w_w), .f_data(f_w), .score(score_w), .score_valid(val_w)
`ifdef SCORE_SATURATE_EN
    , .sat_flag(sat_w)
`endif
  );

  class_score_accumulator #(.NUM_CELLS(N), .WEIGHT_BITS(8), .FEAT_BITS(8), .ACC_BITS(AN)) u_narrow (
    .clk(clk), .rst(rst), .start(start), .busy(busy_n), .cell_addr(addr_n),
    .w_data(w_n), .f_data(f_n), .score(score_n), .score_valid(val_n)
`ifdef SCORE_SATURATE_EN
    , .sat_flag(sat_n)
`endif
  );

  // synchronous-read memories, one read port per DUT
  always @(posedge clk) begin
    w_w <= 8'(wrom[addr_w]);
    f_w <= 8'(from[addr_w]);
    w_n <= 8'(wrom[addr_n]);
    f_n <= 8'(from[addr_n]);
  end

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // dot product over the current contents in scan order, wrapped or clamped to accb bits
  function automatic longint score_of(input int accb);
    longint a = 0;
    longint lim = longint'(1) <<< (accb - 1);
    for (int c = 0; c < N; c++) begin
      a = a + longint'(wrom[c]) * longint'(from[c]);
      if (SAT) begin
        if (a > lim - 1) a = lim - 1;
        else if (a < -lim) a = -lim;
      end else begin
        a = a & (2 * lim - 1);
        if (a >= lim) a = a - 2 * lim;
      end
    end
    return a;
  endfunction

  function automatic bit clamped_of(input int accb);
    longint a = 0;
    longint lim = longint'(1) <<< (accb - 1);
    bit hit = 1'b0;
    for (int c = 0; c < N; c++) begin
      a = a + longint'(wrom[c]) * longint'(from[c]);
      if (a > lim - 1) begin a = lim - 1; hit = 1'b1; end
      else if (a < -lim) begin a = -lim; hit = 1'b1; end
    end
    return SAT && hit;
  endfunction

  // model: a scan runs N+2 cycles after acceptance, then publishes the precomputed result for one cycle
  bit     m_busy = 1'b0, m_valid = 1'b0;
  int     m_cnt = 0;
  longint m_sw = 0, m_sn = 0, p_sw = 0, p_sn = 0;
  bit     m_fw = 1'b0, m_fn = 1'b0, p_fw = 1'b0, p_fn = 1'b0;

  always @(posedge clk) begin
    m_valid <= 1'b0;
    if (rst) begin
      m_busy <= 1'b0; m_cnt <= 0; m_sw <= 0; m_sn <= 0; m_fw <= 1'b0; m_fn <= 1'b0;
    end else if (!m_busy) begin
      if (start) begin
        m_busy <= 1'b1; m_cnt <= 0; m_fw <= 1'b0; m_fn <= 1'b0;
        p_sw <= score_of(AW); p_sn <= score_of(AN);
        p_fw <= clamped_of(AW); p_fn <= clamped_of(AN);
      end
    end else begin
      m_cnt <= m_cnt + 1;
      if (m_cnt == N + 1) begin
        m_busy <= 1'b0; m_valid <= 1'b1;
        m_sw <= p_sw; m_sn <= p_sn; m_fw <= p_fw; m_fn <= p_fn;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      longint ea;
      ea = m_busy ? ((m_cnt < N - 1) ? m_cnt : N - 1) : 0;
      chk("busy_w", busy_w, m_busy);
      chk("busy_n", busy_n, m_busy);
      chk("valid_w", val_w, m_valid);
      chk("valid_n", val_n, m_valid);
      chk("addr_w", addr_w, ea);
      chk("addr_n", addr_n, ea);
      chk("score_w", longint'($signed(score_w)), m_sw);
      chk("score_n", longint'($signed(score_n)), m_sn);
`ifdef SCORE_SATURATE_EN
      chk("sat_w", sat_w, m_fw);
      chk("sat_n", sat_n, m_fn);
`endif
    end
  end

  task automatic set_weights(input bit down);
    for (int c = 0; c < N; c++) begin
      int row, wt;
      row = c / 16;
      wt = (row < 8) ? 6 * (8 - row) : -4 * (row - 7);
      wrom[c] = down ? -wt : wt;
    end
  endtask

  task automatic set_feat_all(input int v);
    for (int c = 0; c < N; c++) from[c] = v;
  endtask

  // called at a negedge; start is seen by exactly one rising edge
  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    set_weights(1'b0);
    set_feat_all(0);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy_w, 0);
    chk("rst_score", longint'($signed(score_w)), 0);
    chk("rst_valid", val_w, 0);
    chk("rst_addr", addr_w, 0);
    chk_en = 1'b1;
    rst = 1'b0;
    @(negedge clk);

    // A: zero features
    pulse_start();
    chk("A_addr0", addr_w, 0);
    chk("A_busy", busy_w, 1);
    repeat (257) @(negedge clk);
    chk("A_not_yet", val_w, 0);
    @(negedge clk);
    chk("A_valid", val_w, 1);
    chk("A_score", longint'($signed(score_w)), 0);
    @(negedge clk);
    chk("A_once", val_w, 0);

    // B: ones with UP, then C back-to-back with DOWN and a stray start at cycle 100
    set_feat_all(1);
    pulse_start();
    repeat (258) @(negedge clk);
    chk("B_valid", val_w, 1);
    chk("B_score_w", longint'($signed(score_w)), 1152);
    chk("B_score_n", longint'($signed(score_n)), 1152);
    set_weights(1'b1);
    pulse_start();
    chk("C_b2b_busy", busy_w, 1);
    repeat (99) @(negedge clk);
    pulse_start();
    repeat (158) @(negedge clk);
    chk("C_valid", val_w, 1);
    chk("C_score_w", longint'($signed(score_w)), -1152);
    chk("C_score_n", longint'($signed(score_n)), -1152);

    // D: single hot cell at address 0
    set_weights(1'b0);
    set_feat_all(0);
    from[0] = 255;
    repeat (2) @(negedge clk);
    pulse_start();
    repeat (258) @(negedge clk);
    chk("D_score_w", longint'($signed(score_w)), 12240);
    chk("D_score_n", longint'($signed(score_n)), 12240);

    // E: full-scale features overflow the 16-bit instance
    set_feat_all(255);
    repeat (2) @(negedge clk);
    pulse_start();
    repeat (99) @(negedge clk);
    pulse_start();
    repeat (158) @(negedge clk);
    chk("E_valid", val_w, 1);
    chk("E_score_w", longint'($signed(score_w)), 293760);
    chk("E_score_n", longint'($signed(score_n)), SAT ? -32768 : 31616);
`ifdef SCORE_SATURATE_EN
    chk("E_sat_n", sat_n, 1);
    chk("E_sat_w", sat_w, 0);
`endif

    // F: reset at cycle 50 discards the scan
    set_feat_all(1);
    repeat (3) @(negedge clk);
    pulse_start();
    repeat (49) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("F_busy", busy_w, 0);
    chk("F_score", longint'($signed(score_w)), 0);
    repeat (260) @(negedge clk);
    chk("F_still_zero", longint'($signed(score_w)), 0);

    // G: clean scan after the reset
    pulse_start();
    repeat (258) @(negedge clk);
    chk("G_valid", val_w, 1);
    chk("G_score_w", longint'($signed(score_w)), 1152);
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
